// File: rtl/rp_acq_seq.sv
// Acquisition sequencer for one channel group: arms a capture, enforces a
// pre-trigger fill, hands the trigger source to the selector and times the post-trigger delay.
module rp_acq_seq #(
   parameter int PRE_W = 32,
   parameter int DLY_W = 32
) (
   input  logic             adc_clk_i,
   input  logic             adc_rst_i,
   input  logic             arm_i,
   input  logic             rst_do_i,
   input  logic             auto_rearm_i,
   input  logic [3:0]       trg_src_i,
   input  logic [PRE_W-1:0] pre_len_i,
   input  logic [DLY_W-1:0] dly_len_i,
   input  logic             dec_en_i,
   input  logic             adc_trig_i,
   output logic             set_trg_new_o,
   output logic [3:0]       set_trg_src_o,
   output logic             adc_rst_do_o,
   output logic             adc_dly_do_o,
   output logic             trig_dis_clr_o,
   output logic             wr_en_o,
   output logic             acq_done_o,
   output logic [2:0]       state_o,
   output logic [PRE_W-1:0] pre_cnt_o,
   output logic [DLY_W-1:0] dly_cnt_o
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_PRE  = 3'd1,
      S_WAIT = 3'd2,
      S_POST = 3'd3,
      S_DONE = 3'd4
   } state_t;

   localparam logic [PRE_W-1:0] PRE_ONE = {{(PRE_W-1){1'b0}}, 1'b1};
   localparam logic [DLY_W-1:0] DLY_ONE = {{(DLY_W-1){1'b0}}, 1'b1};

   state_t           state_q, state_d;
   logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
   logic [DLY_W-1:0] dly_cnt_q, dly_cnt_d;
   logic [3:0]       src_q, src_d;
   logic             set_new_q, set_new_d;
   logic             rst_do_q, rst_do_d;
   logic             dly_do_q, dly_do_d;
   logic             clr_q, clr_d;
   logic             wr_en_q, wr_en_d;
   logic             done_q, done_d;

   always_comb begin
      state_d   = state_q;
      pre_cnt_d = pre_cnt_q;
      dly_cnt_d = dly_cnt_q;
      src_d     = src_q;
      set_new_d = 1'b0;
      rst_do_d  = 1'b0;
      dly_do_d  = 1'b0;
      clr_d     = 1'b0;
      done_d    = done_q;
      wr_en_d   = 1'b0;

      // Abort beats arm, arm beats auto re-arm, and both beat internal progress.
      if (rst_do_i) begin
         state_d   = S_IDLE;
         pre_cnt_d = '0;
         dly_cnt_d = '0;
         done_d    = 1'b0;
         rst_do_d  = 1'b1;
      end else if (arm_i || (state_q == S_DONE && auto_rearm_i)) begin
         state_d   = S_PRE;
         pre_cnt_d = '0;
         dly_cnt_d = '0;
         done_d    = 1'b0;
         clr_d     = 1'b1;
      end else begin
         case (state_q)
            S_PRE: begin
               if (dec_en_i && pre_cnt_q != '1) pre_cnt_d = pre_cnt_q + PRE_ONE;
               if (pre_cnt_q >= pre_len_i) begin
                  state_d   = S_WAIT;
                  set_new_d = 1'b1;
                  src_d     = trg_src_i;
               end
            end
            S_WAIT: begin
               if (dec_en_i && pre_cnt_q != '1) pre_cnt_d = pre_cnt_q + PRE_ONE;
               // A zero source never fires in the selector; hold here until abort/arm.
               if (adc_trig_i && src_q != 4'd0) begin
                  state_d   = S_POST;
                  dly_cnt_d = '0;
               end
            end
            S_POST: begin
               // The count freezes on the completing cycle so DONE reports the reached value.
               if (dly_cnt_q >= dly_len_i) begin
                  state_d  = S_DONE;
                  dly_do_d = 1'b1;
                  done_d   = 1'b1;
               end else if (dec_en_i && dly_cnt_q != '1) begin
                  dly_cnt_d = dly_cnt_q + DLY_ONE;
               end
            end
            default: ;
         endcase
      end

      wr_en_d = dec_en_i && (state_d == S_PRE || state_d == S_WAIT || state_d == S_POST);
   end

   always_ff @(posedge adc_clk_i) begin
      if (adc_rst_i) begin
         state_q   <= S_IDLE;
         pre_cnt_q <= '0;
         dly_cnt_q <= '0;
         src_q     <= 4'd0;
         set_new_q <= 1'b0;
         rst_do_q  <= 1'b0;
         dly_do_q  <= 1'b0;
         clr_q     <= 1'b0;
         wr_en_q   <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         pre_cnt_q <= pre_cnt_d;
         dly_cnt_q <= dly_cnt_d;
         src_q     <= src_d;
         set_new_q <= set_new_d;
         rst_do_q  <= rst_do_d;
         dly_do_q  <= dly_do_d;
         clr_q     <= clr_d;
         wr_en_q   <= wr_en_d;
         done_q    <= done_d;
      end
   end

   assign set_trg_new_o  = set_new_q;
   assign set_trg_src_o  = src_q;
   assign adc_rst_do_o   = rst_do_q;
   assign adc_dly_do_o   = dly_do_q;
   assign trig_dis_clr_o = clr_q;
   assign wr_en_o        = wr_en_q;
   assign acq_done_o     = done_q;
   assign state_o        = state_q;
   assign pre_cnt_o      = pre_cnt_q;
   assign dly_cnt_o      = dly_cnt_q;

endmodule
